// File: rtl/ahbs2wbm_pkg.sv
// Shared AHB / WISHBONE encodings and bridge request payload for ahbs2wbm.
package ahbs2wbm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic [2:0] WBCTI_CLASSIC = 3'b000;
  localparam logic [1:0] WBBTE_LINEAR  = 2'b00;

  // Captured address phase, replayed on the WB master port
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
  } ahb_req_t;

  // clog2 that never yields a zero-width vector
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ahbs2wbm_lane.sv
// Little-endian byte-lane decode of an AHB transfer; flags misaligned or oversized accesses.
module ahbs2wbm_lane
  import ahbs2wbm_pkg::*;
(
  input  logic [2:0] i_hsize,
  input  logic [1:0] i_addr,
  output logic [3:0] o_sel_c,
  output logic       o_decode_err_c
);

  always_comb begin
    o_sel_c        = 4'b0000;
    o_decode_err_c = 1'b0;
    case (i_hsize)
      HSIZE_BYTE: o_sel_c = 4'b0001 << i_addr;
      HSIZE_HWORD: begin
        o_sel_c        = i_addr[1] ? 4'b1100 : 4'b0011;
        o_decode_err_c = i_addr[0];
      end
      HSIZE_WORD: begin
        o_sel_c        = 4'b1111;
        o_decode_err_c = (i_addr != 2'b00);
      end
      default: o_decode_err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahbs2wbm.sv
// AHB slave to classic WISHBONE master bridge: one WB cycle per AHB beat,
// ack/err/rty mapped to OKAY/ERROR/RETRY, with an optional WB wait timeout.
module ahbs2wbm
  import ahbs2wbm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ahbsi_hsel,
  input  logic [31:0] ahbsi_haddr,
  input  logic        ahbsi_hwrite,
  input  logic [1:0]  ahbsi_htrans,
  input  logic [2:0]  ahbsi_hsize,
  input  logic [2:0]  ahbsi_hburst,
  input  logic [31:0] ahbsi_hwdata,
  input  logic        ahbsi_hready,
  output logic        ahbso_hready,
  output logic [1:0]  ahbso_hresp,
  output logic [31:0] ahbso_hrdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int unsigned CNT_W = clog2_min1(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BUS   = 2'b01;
  localparam logic [1:0] ST_RESP1 = 2'b10;
  localparam logic [1:0] ST_RESP2 = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  ahb_req_t         r_req;
  ahb_req_t         w_req;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hready;
  logic             w_hready_nxt;
  logic [1:0]       r_hresp;
  logic [1:0]       w_hresp_nxt;
  logic [31:0]      r_hrdata;
  logic             r_cyc;
  logic             w_cyc_nxt;
  logic [3:0]       w_sel;
  logic             w_dec_err;
  logic             w_capture;
  logic             w_expired;
  logic             w_rd_ack;
  logic             w_unused;

  ahbs2wbm_lane u_lane (
    .i_hsize        (ahbsi_hsize),
    .i_addr         (ahbsi_haddr[1:0]),
    .o_sel_c        (w_sel),
    .o_decode_err_c (w_dec_err)
  );

  assign w_capture = ahbsi_hsel && ahbsi_hready &&
                     ((ahbsi_htrans == HTRANS_NONSEQ) || (ahbsi_htrans == HTRANS_SEQ)) &&
                     ((r_state == ST_IDLE) || (r_state == ST_RESP2));
  // Fires on the last permitted wait cycle so RESP1 lands TIMEOUT cycles after stb rises
  assign w_expired = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_rd_ack  = (r_state == ST_BUS) && wb_ack_i && !wb_err_i && !wb_rty_i && !r_req.we;
  assign w_req     = '{addr: ahbsi_haddr, we: ahbsi_hwrite, sel: w_sel};
  assign w_unused  = ^ahbsi_hburst;

  always_comb begin
    w_state_nxt = r_state;
    w_hresp_nxt = HRESP_OKAY;
    case (r_state)
      ST_IDLE, ST_RESP2: begin
        w_state_nxt = ST_IDLE;
        if (w_capture) begin
          if (w_dec_err) begin
            w_state_nxt = ST_RESP1;
            w_hresp_nxt = HRESP_ERROR;
          end else begin
            w_state_nxt = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (wb_err_i) begin
          w_state_nxt = ST_RESP1;
          w_hresp_nxt = HRESP_ERROR;
        end else if (wb_rty_i) begin
          w_state_nxt = ST_RESP1;
          w_hresp_nxt = HRESP_RETRY;
        end else if (wb_ack_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expired) begin
          w_state_nxt = ST_RESP1;
          w_hresp_nxt = HRESP_ERROR;
        end
      end
      ST_RESP1: begin
        w_state_nxt = ST_RESP2;
        w_hresp_nxt = r_hresp;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_hready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RESP2);
    w_cyc_nxt    = (w_state_nxt == ST_BUS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_req    <= '0;
      r_cnt    <= '0;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
      r_hrdata <= '0;
      r_cyc    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hready <= w_hready_nxt;
      r_hresp  <= w_hresp_nxt;
      r_cyc    <= w_cyc_nxt;
      if (w_capture) r_req <= w_req;
      r_cnt <= (r_state == ST_BUS) ? r_cnt + CNT_W'(1) : '0;
      if (w_rd_ack) r_hrdata <= wb_dat_i;
    end
  end

  assign ahbso_hready = r_hready;
  assign ahbso_hresp  = r_hresp;
  assign ahbso_hrdata = r_hrdata;
  assign wb_adr_o     = r_req.addr;
  assign wb_sel_o     = r_req.sel;
  assign wb_we_o      = r_req.we;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_cyc;
  assign wb_dat_o     = ahbsi_hwdata;
  assign wb_cti_o     = WBCTI_CLASSIC;
  assign wb_bte_o     = WBBTE_LINEAR;

endmodule

// File: tb/tb_ahbs2wbm.sv
// Directed bench for ahbs2wbm: main instance (TIMEOUT=255) plus TIMEOUT=4 and TIMEOUT=0 instances.
module tb_ahbs2wbm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b000;
  logic [2:0]  hburst = 3'b001;
  logic [31:0] hwdata = '0;
  logic        bus_hready;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;

  logic        hready, t4_hready, t0_hready;
  logic [1:0]  hresp, t4_hresp, t0_hresp;
  logic [31:0] hrdata, t4_hrdata, t0_hrdata;
  logic [31:0] adr, t4_adr, t0_adr;
  logic [31:0] dat_o, t4_dat_o, t0_dat_o;
  logic [3:0]  sel, t4_sel, t0_sel;
  logic        we, t4_we, t0_we;
  logic        cyc, t4_cyc, t0_cyc;
  logic        stb, t4_stb, t0_stb;
  logic [2:0]  cti, t4_cti, t0_cti;
  logic [1:0]  bte, t4_bte, t0_bte;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign bus_hready = hready;

  ahbs2wbm #(.TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .ahbsi_hsel(hsel), .ahbsi_haddr(haddr), .ahbsi_hwrite(hwrite),
    .ahbsi_htrans(htrans), .ahbsi_hsize(hsize), .ahbsi_hburst(hburst), .ahbsi_hwdata(hwdata),
    .ahbsi_hready(bus_hready), .ahbso_hready(hready), .ahbso_hresp(hresp), .ahbso_hrdata(hrdata),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_we_o(we), .wb_cyc_o(cyc), .wb_stb_o(stb),
    .wb_cti_o(cti), .wb_bte_o(bte), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  ahbs2wbm #(.TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .ahbsi_hsel(hsel), .ahbsi_haddr(haddr), .ahbsi_hwrite(hwrite),
    .ahbsi_htrans(htrans), .ahbsi_hsize(hsize), .ahbsi_hburst(hburst), .ahbsi_hwdata(hwdata),
    .ahbsi_hready(bus_hready), .ahbso_hready(t4_hready), .ahbso_hresp(t4_hresp), .ahbso_hrdata(t4_hrdata),
    .wb_adr_o(t4_adr), .wb_dat_o(t4_dat_o), .wb_sel_o(t4_sel), .wb_we_o(t4_we), .wb_cyc_o(t4_cyc),
    .wb_stb_o(t4_stb), .wb_cti_o(t4_cti), .wb_bte_o(t4_bte), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  ahbs2wbm #(.TIMEOUT(0)) dut_t0 (
    .clk(clk), .rst_n(rst_n), .ahbsi_hsel(hsel), .ahbsi_haddr(haddr), .ahbsi_hwrite(hwrite),
    .ahbsi_htrans(htrans), .ahbsi_hsize(hsize), .ahbsi_hburst(hburst), .ahbsi_hwdata(hwdata),
    .ahbsi_hready(bus_hready), .ahbso_hready(t0_hready), .ahbso_hresp(t0_hresp), .ahbso_hrdata(t0_hrdata),
    .wb_adr_o(t0_adr), .wb_dat_o(t0_dat_o), .wb_sel_o(t0_sel), .wb_we_o(t0_we), .wb_cyc_o(t0_cyc),
    .wb_stb_o(t0_stb), .wb_cti_o(t0_cti), .wb_bte_o(t0_bte), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
    hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({hready, hresp, cyc, stb, we} !== 6'b1_00_000) begin
      errors++; $display("FAIL reset_ctrl: got %b exp %b", {hready, hresp, cyc, stb, we}, 6'b1_00_000);
    end
    checks++;
    if (hrdata !== 32'h0) begin
      errors++; $display("FAIL reset_hrdata: got %h exp %h", hrdata, 32'h0);
    end
    checks++;
    if ({adr, sel} !== 36'h0) begin
      errors++; $display("FAIL reset_adr_sel: got %h exp %h", {adr, sel}, 36'h0);
    end
    checks++;
    if ({cti, bte} !== 5'b000_00) begin
      errors++; $display("FAIL reset_cti_bte: got %b exp %b", {cti, bte}, 5'b0);
    end
    checks++;
    if ({t4_cyc, t4_hready, t0_cyc, t0_hready} !== 4'b0101) begin
      errors++; $display("FAIL reset_aux: got %b exp %b", {t4_cyc, t4_hready, t0_cyc, t0_hready}, 4'b0101);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    addr_phase(32'h40, 1'b0, 3'b010, 2'b10);
    tick();  // A+1
    idle_bus();
    checks++;
    if ({t4_cyc, t4_stb, t4_hready} !== 3'b110) begin
      errors++; $display("FAIL to4_stb_rise: got %b exp %b", {t4_cyc, t4_stb, t4_hready}, 3'b110);
    end
    tick(); tick(); tick();  // A+4
    checks++;
    if ({t4_cyc, t4_stb, t4_hready, t4_hresp} !== 5'b110_00) begin
      errors++; $display("FAIL to4_last_wait: got %b exp %b", {t4_cyc, t4_stb, t4_hready, t4_hresp}, 5'b110_00);
    end
    tick();  // A+5
    checks++;
    if ({t4_cyc, t4_stb, t4_hready, t4_hresp} !== 5'b000_01) begin
      errors++; $display("FAIL to4_resp1: got %b exp %b", {t4_cyc, t4_stb, t4_hready, t4_hresp}, 5'b000_01);
    end
    tick();  // A+6
    checks++;
    if ({t4_cyc, t4_stb, t4_hready, t4_hresp} !== 5'b001_01) begin
      errors++; $display("FAIL to4_resp2: got %b exp %b", {t4_cyc, t4_stb, t4_hready, t4_hresp}, 5'b001_01);
    end
    tick();  // A+7
    checks++;
    if ({t4_cyc, t4_hready, t4_hresp} !== 4'b0_1_00) begin
      errors++; $display("FAIL to4_idle: got %b exp %b", {t4_cyc, t4_hready, t4_hresp}, 4'b0_1_00);
    end
    repeat (30) tick();
    checks++;
    if ({t0_cyc, t0_stb, t0_hready, t0_hresp} !== 5'b110_00) begin
      errors++; $display("FAIL to0_stall: got %b exp %b", {t0_cyc, t0_stb, t0_hready, t0_hresp}, 5'b110_00);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({cyc, t0_cyc, t4_cyc, hready, t0_hready} !== 5'b000_11) begin
      errors++; $display("FAIL to_reset: got %b exp %b", {cyc, t0_cyc, t4_cyc, hready, t0_hready}, 5'b000_11);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    addr_phase(32'h100, 1'b1, 3'b010, 2'b10);
    tick();  // A+1
    idle_bus();
    hwdata = 32'hDEADBEEF;
    wb_ack_i = 1'b1;
    #1;
    checks++;
    if ({cyc, stb, we, hready} !== 4'b1110) begin
      errors++; $display("FAIL wr_ctrl: got %b exp %b", {cyc, stb, we, hready}, 4'b1110);
    end
    checks++;
    if ({adr, sel} !== {32'h100, 4'hF}) begin
      errors++; $display("FAIL wr_adr_sel: got %h exp %h", {adr, sel}, {32'h100, 4'hF});
    end
    checks++;
    if (dat_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_data: got %h exp %h", dat_o, 32'hDEADBEEF);
    end
    tick();  // A+2
    wb_ack_i = 1'b0;
    checks++;
    if ({hready, hresp, cyc, stb} !== 5'b1_00_00) begin
      errors++; $display("FAIL wr_okay: got %b exp %b", {hready, hresp, cyc, stb}, 5'b1_00_00);
    end
  endtask

  task automatic test_read();
    addr_phase(32'h203, 1'b0, 3'b000, 2'b10);
    tick();  // A+1
    idle_bus();
    checks++;
    if ({cyc, stb, we, hready} !== 4'b1100) begin
      errors++; $display("FAIL rd_ctrl: got %b exp %b", {cyc, stb, we, hready}, 4'b1100);
    end
    checks++;
    if ({adr, sel} !== {32'h203, 4'b1000}) begin
      errors++; $display("FAIL rd_adr_sel: got %h exp %h", {adr, sel}, {32'h203, 4'b1000});
    end
    tick(); tick();  // A+3
    checks++;
    if ({hready, stb} !== 2'b01) begin
      errors++; $display("FAIL rd_wait: got %b exp %b", {hready, stb}, 2'b01);
    end
    tick();  // A+4
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h11223344;
    tick();  // A+5
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    checks++;
    if ({hready, hresp, cyc} !== 4'b1_00_0) begin
      errors++; $display("FAIL rd_okay: got %b exp %b", {hready, hresp, cyc}, 4'b1_00_0);
    end
    checks++;
    if (hrdata !== 32'h11223344) begin
      errors++; $display("FAIL rd_hrdata: got %h exp %h", hrdata, 32'h11223344);
    end
  endtask

  task automatic test_decode_err();
    addr_phase(32'h001, 1'b0, 3'b001, 2'b10);
    tick();  // A+1
    idle_bus();
    checks++;
    if ({cyc, stb, hready, hresp} !== 5'b00_0_01) begin
      errors++; $display("FAIL dec_resp1: got %b exp %b", {cyc, stb, hready, hresp}, 5'b00_0_01);
    end
    tick();  // A+2
    checks++;
    if ({cyc, stb, hready, hresp} !== 5'b00_1_01) begin
      errors++; $display("FAIL dec_resp2: got %b exp %b", {cyc, stb, hready, hresp}, 5'b00_1_01);
    end
    tick();  // A+3
    checks++;
    if ({cyc, stb, hready, hresp} !== 5'b00_1_00) begin
      errors++; $display("FAIL dec_idle: got %b exp %b", {cyc, stb, hready, hresp}, 5'b00_1_00);
    end
  endtask

  task automatic test_retry();
    addr_phase(32'h300, 1'b1, 3'b010, 2'b10);
    tick();  // A+1
    idle_bus();
    hwdata = 32'hCAFEF00D;
    wb_rty_i = 1'b1;
    #1;
    checks++;
    if ({cyc, stb, we, dat_o} !== {3'b111, 32'hCAFEF00D}) begin
      errors++; $display("FAIL rty_bus: got %h exp %h", {cyc, stb, we, dat_o}, {3'b111, 32'hCAFEF00D});
    end
    tick();  // A+2
    wb_rty_i = 1'b0;
    checks++;
    if ({cyc, hready, hresp} !== 4'b0_0_10) begin
      errors++; $display("FAIL rty_resp1: got %b exp %b", {cyc, hready, hresp}, 4'b0_0_10);
    end
    tick();  // A+3
    checks++;
    if ({cyc, hready, hresp} !== 4'b0_1_10) begin
      errors++; $display("FAIL rty_resp2: got %b exp %b", {cyc, hready, hresp}, 4'b0_1_10);
    end
    tick();  // A+4
    checks++;
    if ({cyc, hready, hresp} !== 4'b0_1_00) begin
      errors++; $display("FAIL rty_idle: got %b exp %b", {cyc, hready, hresp}, 4'b0_1_00);
    end
  endtask

  task automatic test_err_ack();
    addr_phase(32'h400, 1'b0, 3'b010, 2'b10);
    tick();  // A+1
    idle_bus();
    wb_err_i = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hFFFF0000;
    tick();  // A+2
    wb_err_i = 1'b0;
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    checks++;
    if ({cyc, hready, hresp} !== 4'b0_0_01) begin
      errors++; $display("FAIL errack_resp1: got %b exp %b", {cyc, hready, hresp}, 4'b0_0_01);
    end
    checks++;
    if (hrdata !== 32'h11223344) begin
      errors++; $display("FAIL errack_hrdata_hold: got %h exp %h", hrdata, 32'h11223344);
    end
    tick();  // A+3
    checks++;
    if ({cyc, hready, hresp} !== 4'b0_1_01) begin
      errors++; $display("FAIL errack_resp2: got %b exp %b", {cyc, hready, hresp}, 4'b0_1_01);
    end
    tick();
  endtask

  task automatic test_burst_reset();
    addr_phase(32'h500, 1'b0, 3'b010, 2'b10);
    tick();  // A+1: beat 1 on WB, beat 2 address held
    checks++;
    if ({stb, adr} !== {1'b1, 32'h500}) begin
      errors++; $display("FAIL burst_b1: got %h exp %h", {stb, adr}, {1'b1, 32'h500});
    end
    addr_phase(32'h504, 1'b0, 3'b010, 2'b11);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hA0000001;
    tick();  // A+2
    wb_ack_i = 1'b0;
    checks++;
    if ({hready, hresp, stb, hrdata} !== {4'b1_00_0, 32'hA0000001}) begin
      errors++; $display("FAIL burst_b1_okay: got %h exp %h", {hready, hresp, stb, hrdata}, {4'b1_00_0, 32'hA0000001});
    end
    tick();  // A+3
    checks++;
    if ({stb, adr} !== {1'b1, 32'h504}) begin
      errors++; $display("FAIL burst_b2: got %h exp %h", {stb, adr}, {1'b1, 32'h504});
    end
    htrans = 2'b01;
    haddr = 32'h508;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hA0000002;
    tick();  // A+4: beat 2 OKAY, BUSY address phase completes
    wb_ack_i = 1'b0;
    checks++;
    if ({hready, hresp, stb, hrdata} !== {4'b1_00_0, 32'hA0000002}) begin
      errors++; $display("FAIL burst_b2_okay: got %h exp %h", {hready, hresp, stb, hrdata}, {4'b1_00_0, 32'hA0000002});
    end
    tick();  // A+5
    checks++;
    if ({hready, hresp, stb} !== 4'b1_00_0) begin
      errors++; $display("FAIL burst_busy_okay: got %b exp %b", {hready, hresp, stb}, 4'b1_00_0);
    end
    htrans = 2'b11;
    tick();  // A+6
    checks++;
    if ({stb, adr} !== {1'b1, 32'h508}) begin
      errors++; $display("FAIL burst_b3: got %h exp %h", {stb, adr}, {1'b1, 32'h508});
    end
    haddr = 32'h50C;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hA0000003;
    tick();  // A+7
    wb_ack_i = 1'b0;
    checks++;
    if ({hready, hrdata} !== {1'b1, 32'hA0000003}) begin
      errors++; $display("FAIL burst_b3_okay: got %h exp %h", {hready, hrdata}, {1'b1, 32'hA0000003});
    end
    tick();  // A+8
    checks++;
    if ({stb, adr} !== {1'b1, 32'h50C}) begin
      errors++; $display("FAIL burst_b4: got %h exp %h", {stb, adr}, {1'b1, 32'h50C});
    end
    rst_n = 1'b0;
    idle_bus();
    tick();  // A+9
    checks++;
    if ({hready, hresp, cyc, stb, we} !== 6'b1_00_000) begin
      errors++; $display("FAIL burst_rst_ctrl: got %b exp %b", {hready, hresp, cyc, stb, we}, 6'b1_00_000);
    end
    checks++;
    if ({hrdata, adr, sel} !== 68'h0) begin
      errors++; $display("FAIL burst_rst_data: got %h exp %h", {hrdata, adr, sel}, 68'h0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_write();
    test_read();
    test_decode_err();
    test_retry();
    test_err_ack();
    test_burst_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbs2wbm.md
# ahbs2wbm

AHB slave to WISHBONE master bridge. It accepts single and burst AHB transfers as an AHB slave and replays each beat as a classic WISHBONE cycle on the WB master port. WISHBONE responses (ack/err/rty) map back to AHB OKAY/ERROR/RETRY, and a timeout guards against WB slaves that never respond. It sits between the AHB fabric and WB-only peripherals; it is the counterpart of the existing WB-slave-to-AHB-master bridge.

## Interface
- TIMEOUT, 255: maximum WB wait cycles before the bridge forces an ERROR response; 0 disables the timeout.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ahbsi_hsel  in  1  slave select
- ahbsi_haddr  in  32  address
- ahbsi_hwrite  in  1  1 = write
- ahbsi_htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- ahbsi_hsize  in  3  BYTE/HWORD/WORD; larger values are an error
- ahbsi_hburst  in  3  accepted, ignored
- ahbsi_hwdata  in  32  write data, data phase
- ahbsi_hready  in  1  bus-level HREADY
- ahbso_hready  out  1  HREADYOUT
- ahbso_hresp  out  2  OKAY/ERROR/RETRY
- ahbso_hrdata  out  32  read data, registered
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte lanes
- wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  WB control
- wb_cti_o  out  3  constant WBCTI_CLASSIC
- wb_bte_o  out  2  constant WBBTE_LINEAR
- wb_dat_i  in  32  read data
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  WB termination

## Operation

**Address phase capture.** An address phase is captured when all of the following hold in the same cycle:
- ahbsi_hsel = 1
- ahbsi_hready = 1
- ahbsi_htrans is NONSEQ or SEQ
- the bridge is in IDLE or RESP2

Capture registers haddr, hwrite and hsize. BUSY and IDLE transfers are never captured and get a zero-wait OKAY.

**Lane decode (little-endian).**
- BYTE: sel = 1 << haddr[1:0].
- HWORD: haddr[0] = 0 required; sel = 0011 or 1100 per haddr[1].
- WORD: haddr[1:0] = 00 required; sel = 1111.
- Misaligned address or hsize > WORD sets a decode error. The bridge issues no WB cycle and goes straight to RESP1 with ERROR.

**State machine.**
- IDLE: hready = 1, hresp = OKAY, no WB cycle. A valid capture goes to BUS, or to RESP1 on a decode error.
- BUS: cyc = stb = 1; adr, sel and we come from the captured registers; wb_dat_o = ahbsi_hwdata passed through combinationally (AHB holds hwdata stable while hready is 0). hready = 0.
  - ack: latch wb_dat_i into hrdata on reads, drop cyc/stb, go to IDLE.
  - err: go to RESP1 with ERROR.
  - rty: go to RESP1 with RETRY.
  - Timeout expiry: same as err.
  - Priority when several arrive together: err > rty > ack.
- RESP1: hready = 0, hresp = latched code. Always goes to RESP2 next cycle.
- RESP2: hready = 1, hresp = latched code. A capture in this cycle is honoured (to BUS or RESP1); otherwise go to IDLE.

**Timeout counter.**
- Width is clog2(TIMEOUT+1). It clears on BUS entry and increments each BUS cycle without a termination.
- When the count equals TIMEOUT, the bridge terminates with ERROR and drops cyc/stb.

**Other behaviour.**
- hrdata holds its last value; it is not updated on writes or errors.
- Reset mid-operation: cyc/stb drop in the same cycle reset is sampled and the state returns to IDLE. The AHB transfer in flight is abandoned.

## Timing
- Reset values:
  - ahbso_hready = 1, hresp = OKAY, hrdata = 0
  - wb_cyc_o = wb_stb_o = wb_we_o = 0
  - wb_adr_o = 0, wb_sel_o = 0
  - wb_cti_o = 000, wb_bte_o = 00
- Address phase in cycle A. stb is asserted in A+1. With ack in cycle A+k (k ≥ 1), ahbso_hready = 1 and hrdata is valid in A+k+1.
- Minimum transfer is 1 wait state. Back-to-back beats: the next address is captured in the OKAY cycle A+k+1 and its stb rises in A+k+2. One idle WB cycle separates beats.
- ERROR/RETRY is exactly two cycles: RESP1 with hready = 0, then RESP2 with hready = 1.
- Decode error: RESP1 occurs in A+1 and no stb is ever asserted.
- Timeout: with TIMEOUT = N and no WB response, RESP1 occurs in cycle A+N+1.
- wb_cyc_o equals wb_stb_o at all times; there is no lock.

## Structure
- Shared constants come from the existing amba.v / wishbone.v / fun.v includes: HTRANS_*, HRESP_*, HSIZE_*, WBCTI_*, WBBTE_* and the clog2 helper. No new constants are local to this block.
- One combinational sub-module, ahbs2wbm_lane.
  - Inputs: hsize, haddr[1:0].
  - Outputs: sel[3:0], decode_err.
  - It is also reused by future AHB slaves.

## Test plan
- WORD write to 0x100, hwdata 0xDEADBEEF, ack on the first stb cycle -> adr 0x100, sel 1111, we = 1, dat 0xDEADBEEF; hready low 1 cycle, OKAY.
- BYTE read at 0x203, ack after 3 waits with wb_dat_i 0x11223344 -> sel 1000; hrdata 0x11223344 in A+5.
- HWORD at 0x001 -> no stb; hresp ERROR with hready 0 then 1 in A+1/A+2.
- rty on a write -> RETRY two-cycle response. err and ack in the same cycle -> ERROR.
- TIMEOUT = 4, slave silent -> cyc drops and RESP1 occurs in A+5. TIMEOUT = 0 -> bridge stalls indefinitely.
- 4-beat INCR burst with a BUSY between beats 2 and 3, then rst_n low during beat 4's BUS state -> each beat is a separate WB cycle with correct addresses; BUSY gets a zero-wait OKAY; reset drops cyc next edge and all outputs return to reset values.
